mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single off-chip memory port between I-cache miss/refill traffic and D-cache
//  refill/write-back traffic in the pipelined MIPS core. Grants one requester at a time,
//  latches its command, runs the memory transaction to mem_ready and returns a one-cycle
//  ready pulse with the line data. Ties are broken by alternation, so neither cache starves.
// PARAMETERS
//  ADDR_W  28   memory line address width (word address >> 2)
//  LINE_W  128  cache line width in bits
// PORTS
//  clk              in   1       system clock; all state updates on rising edge
//  rst_n            in   1       asynchronous, active-low reset
//  icache_mem_read  in   1       I-cache line read request (level, held until ready)
//  icache_mem_addr  in   ADDR_W  I-cache line address
//  icache_mem_rdata out  LINE_W  line data returned to I-cache
//  icache_mem_ready out  1       one-cycle completion pulse to I-cache
//  dcache_mem_read  in   1       D-cache line read request (level)
//  dcache_mem_write in   1       D-cache write-back request (level)
//  dcache_mem_addr  in   ADDR_W  D-cache line address
//  dcache_mem_wdata in   LINE_W  D-cache write-back data
//  dcache_mem_rdata out  LINE_W  line data returned to D-cache
//  dcache_mem_ready out  1       one-cycle completion pulse to D-cache
//  mem_read         out  1       memory read strobe
//  mem_write        out  1       memory write strobe
//  mem_addr         out  ADDR_W  memory line address
//  mem_wdata        out  LINE_W  memory write data
//  mem_rdata        in   LINE_W  memory read data, valid when mem_ready=1
//  mem_ready        in   1       memory completion
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, last_grant=I, every output and internal register 0.
//    Mid-transaction reset drops mem_read/mem_write immediately; transaction is abandoned.
//  - States: IDLE -> GRANT_I | GRANT_D -> RESP -> IDLE.
//  - IDLE: sample requests. Only I requests -> GRANT_I; only D (read or write) -> GRANT_D.
//    Both request -> grant the side NOT in last_grant. None -> stay IDLE.
//  - On the grant edge: latch addr (and, for D, wdata and op) into command registers;
//    update last_grant. Requester inputs are ignored until the next IDLE.
//  - GRANT_x: mem_read/mem_write/mem_addr/mem_wdata driven from the command registers only
//    (registered outputs; stable for the whole transaction). mem_read asserted on the
//    first cycle after the request is seen in IDLE (1-cycle grant latency).
//  - dcache_mem_read and dcache_mem_write both 1 at grant: treated as a write (write wins).
//  - mem_ready=1 while in GRANT_x: capture mem_rdata into the line register, -> RESP.
//    mem_read/mem_write are 0 from the RESP cycle onward.
//  - RESP: the granted side's *_mem_ready=1 for exactly one cycle, its *_mem_rdata = captured
//    line; -> IDLE. The other side's ready stays 0. For writes, rdata holds its previous value.
//  - *_mem_rdata hold their last value outside RESP (no change until the next capture).
//  - Requester must drop its request the cycle after its ready pulse; the arbiter does not
//    sample requests in RESP, so a held-high request in RESP is never double-granted.
//  - mem_ready in IDLE or RESP: ignored. Total overhead per transaction: 2 cycles
//    (grant + response) plus memory latency.
// TESTING
//  1. Reset: rst_n=0 with mem_read forced active mid-read -> all outputs 0 same cycle; IDLE.
//  2. I-only: icache_mem_read=1, addr=28'h0000040; memory ready after 4 cycles with
//     rdata=128'hDEADBEEF_... -> mem_read rises cycle 1, icache_mem_ready pulses once with
//     that rdata, dcache_mem_ready stays 0.
//  3. Tie after reset: I and D read same cycle -> D granted first (last_grant=I), then I;
//     both get exactly one ready pulse, in that order.
//  4. Alternation: both sides hold requests back-to-back for 6 transactions -> grants
//     alternate D,I,D,I,D,I; no side served twice in a row.
//  5. Write-back: dcache_mem_write=1, addr=28'h0ABCDEF, wdata=128'h1234... -> mem_write=1
//     with exact latched addr/wdata, inputs changed after grant do not reach mem_*.
//  6. Spurious mem_ready in IDLE and dcache read+write together -> ignored; write issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one off-chip line-memory port between I-cache reads and D-cache reads/write-backs.
// Latency : 1 cycle grant + memory latency + 1 cycle response pulse.
// Backpres: requests are levels held until the ready pulse; a held request is only sampled in IDLE.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   icache_mem_read/addr             I-cache line read request
//   icache_mem_rdata/ready           I-cache returned line and one-cycle completion pulse
//   dcache_mem_read/write/addr/wdata D-cache line read or write-back request
//   dcache_mem_rdata/ready           D-cache returned line and one-cycle completion pulse
//   mem_read/write/addr/wdata        memory command, stable for the whole transaction
//   mem_rdata/ready                  memory response
module mem_port_arbiter #(
   parameter int ADDR_W = 28,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_mem_read,
   input  logic [ADDR_W-1:0] icache_mem_addr,
   output logic [LINE_W-1:0] icache_mem_rdata,
   output logic              icache_mem_ready,
   input  logic              dcache_mem_read,
   input  logic              dcache_mem_write,
   input  logic [ADDR_W-1:0] dcache_mem_addr,
   input  logic [LINE_W-1:0] dcache_mem_wdata,
   output logic [LINE_W-1:0] dcache_mem_rdata,
   output logic              dcache_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic SIDE_I = 1'b0;
   localparam logic SIDE_D = 1'b1;

   state_t            state;
   state_t            next_state;
   logic              last_grant;   // side granted most recently; also the side answered in RESP
   logic [ADDR_W-1:0] cmd_addr;
   logic [LINE_W-1:0] cmd_wdata;
   logic              cmd_write;
   logic [LINE_W-1:0] icache_line;
   logic [LINE_W-1:0] dcache_line;

   logic i_req;
   logic d_req;

   assign i_req = icache_mem_read;
   assign d_req = dcache_mem_read | dcache_mem_write;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: on a tie the side that was not served last wins
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (i_req && d_req) begin
               next_state = (last_grant == SIDE_D) ? GRANT_I : GRANT_D;
            end else if (i_req) begin
               next_state = GRANT_I;
            end else if (d_req) begin
               next_state = GRANT_D;
            end
         end
         GRANT_I, GRANT_D: begin
            if (mem_ready) begin
               next_state = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode: strobes depend only on registered state, never on requester inputs
   always_comb begin
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      icache_mem_ready = 1'b0;
      dcache_mem_ready = 1'b0;
      case (state)
         GRANT_I: mem_read = 1'b1;
         GRANT_D: begin
            mem_read  = ~cmd_write;
            mem_write = cmd_write;
         end
         RESP: begin
            icache_mem_ready = (last_grant == SIDE_I);
            dcache_mem_ready = (last_grant == SIDE_D);
         end
         default: ;
      endcase
   end

   // Command latch on the grant edge and line capture on mem_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant  <= SIDE_I;
         cmd_addr    <= '0;
         cmd_wdata   <= '0;
         cmd_write   <= 1'b0;
         icache_line <= '0;
         dcache_line <= '0;
      end else begin
         if (state == IDLE && next_state == GRANT_I) begin
            last_grant <= SIDE_I;
            cmd_addr   <= icache_mem_addr;
            cmd_write  <= 1'b0;
         end else if (state == IDLE && next_state == GRANT_D) begin
            last_grant <= SIDE_D;
            cmd_addr   <= dcache_mem_addr;
            cmd_wdata  <= dcache_mem_wdata;
            // read and write together is a write-back
            cmd_write  <= dcache_mem_write;
         end

         if (state == GRANT_I && mem_ready) begin
            icache_line <= mem_rdata;
         end
         // a write-back leaves the D-cache line untouched
         if (state == GRANT_D && mem_ready && !cmd_write) begin
            dcache_line <= mem_rdata;
         end
      end
   end

   assign mem_addr         = cmd_addr;
   assign mem_wdata        = cmd_wdata;
   assign icache_mem_rdata = icache_line;
   assign dcache_mem_rdata = dcache_line;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single requester, ties, alternation,
// write-back latching, spurious mem_ready and read+write collisions.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 28;
   localparam int LINE_W = 128;

   logic              clk;
   logic              rst_n;
   logic              icache_mem_read;
   logic [ADDR_W-1:0] icache_mem_addr;
   logic [LINE_W-1:0] icache_mem_rdata;
   logic              icache_mem_ready;
   logic              dcache_mem_read;
   logic              dcache_mem_write;
   logic [ADDR_W-1:0] dcache_mem_addr;
   logic [LINE_W-1:0] dcache_mem_wdata;
   logic [LINE_W-1:0] dcache_mem_rdata;
   logic              dcache_mem_ready;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_ready;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .icache_mem_read  (icache_mem_read),
      .icache_mem_addr  (icache_mem_addr),
      .icache_mem_rdata (icache_mem_rdata),
      .icache_mem_ready (icache_mem_ready),
      .dcache_mem_read  (dcache_mem_read),
      .dcache_mem_write (dcache_mem_write),
      .dcache_mem_addr  (dcache_mem_addr),
      .dcache_mem_wdata (dcache_mem_wdata),
      .dcache_mem_rdata (dcache_mem_rdata),
      .dcache_mem_ready (dcache_mem_ready),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .mem_ready        (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // bounded wait for a memory strobe; an expired budget is a failed check
   task automatic wait_grant(input string tag);
      int n;
      n = 0;
      while (!(mem_read || mem_write) && n < 8) begin
         cyc();
         n++;
      end
      chk(tag, 128'(mem_read | mem_write), 128'd1);
   endtask

   localparam logic [127:0] LINE_A   = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
   localparam logic [127:0] LINE_T1  = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] LINE_T2  = 128'h55555555_66666666_77777777_88888888;
   localparam logic [127:0] WDATA_A  = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
   localparam logic [127:0] WDATA_B  = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
   localparam logic [127:0] JUNK     = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

   logic [127:0] last_i;
   logic [127:0] last_d;
   logic [127:0] dk;
   logic         exp_d;

   initial begin
      rst_n            = 1'b0;
      icache_mem_read  = 1'b0;
      icache_mem_addr  = '0;
      dcache_mem_read  = 1'b0;
      dcache_mem_write = 1'b0;
      dcache_mem_addr  = '0;
      dcache_mem_wdata = '0;
      mem_rdata        = '0;
      mem_ready        = 1'b0;

      // ---- 1. reset state, then reset in the middle of a read
      cyc();
      cyc();
      chk("rst_mem_read",  128'(mem_read), 128'd0);
      chk("rst_mem_write", 128'(mem_write), 128'd0);
      chk("rst_mem_addr",  128'(mem_addr), 128'd0);
      chk("rst_i_ready",   128'(icache_mem_ready), 128'd0);
      chk("rst_d_ready",   128'(dcache_mem_ready), 128'd0);
      chk("rst_i_rdata",   icache_mem_rdata, 128'd0);
      rst_n           = 1'b1;
      icache_mem_read = 1'b1;
      icache_mem_addr = 28'h0000777;
      cyc();
      chk("midrd_mem_read", 128'(mem_read), 128'd1);
      chk("midrd_mem_addr", 128'(mem_addr), 128'h0000777);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_mem_read", 128'(mem_read), 128'd0);
      chk("async_rst_mem_addr", 128'(mem_addr), 128'd0);
      icache_mem_read = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("post_rst_idle", 128'(mem_read | mem_write), 128'd0);

      // ---- 2. I-cache only, memory answers in the 4th grant cycle
      icache_mem_read = 1'b1;
      icache_mem_addr = 28'h0000040;
      cyc();
      chk("i_only_mem_read", 128'(mem_read), 128'd1);
      chk("i_only_mem_addr", 128'(mem_addr), 128'h0000040);
      chk("i_only_mem_write", 128'(mem_write), 128'd0);
      repeat (3) begin
         cyc();
         chk("i_only_hold_read", 128'(mem_read), 128'd1);
         chk("i_only_no_ready", 128'(icache_mem_ready), 128'd0);
      end
      mem_ready = 1'b1;
      mem_rdata = LINE_A;
      cyc();
      mem_ready       = 1'b0;
      mem_rdata       = JUNK;
      icache_mem_read = 1'b0;
      chk("i_only_ready",    128'(icache_mem_ready), 128'd1);
      chk("i_only_rdata",    icache_mem_rdata, LINE_A);
      chk("i_only_d_ready",  128'(dcache_mem_ready), 128'd0);
      chk("i_only_rd_drop",  128'(mem_read), 128'd0);
      cyc();
      chk("i_only_pulse_end", 128'(icache_mem_ready), 128'd0);
      chk("i_only_rdata_hold", icache_mem_rdata, LINE_A);

      // ---- 3. tie right after reset: D first, then I
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      chk("rst2_i_rdata", icache_mem_rdata, 128'd0);
      icache_mem_read = 1'b1;
      icache_mem_addr = 28'h0000100;
      dcache_mem_read = 1'b1;
      dcache_mem_addr = 28'h0000200;
      cyc();
      chk("tie_first_is_d", 128'(mem_addr), 128'h0000200);
      chk("tie_first_read", 128'(mem_read), 128'd1);
      mem_ready = 1'b1;
      mem_rdata = LINE_T1;
      cyc();
      mem_ready       = 1'b0;
      dcache_mem_read = 1'b0;
      chk("tie_d_ready", 128'(dcache_mem_ready), 128'd1);
      chk("tie_d_i_quiet", 128'(icache_mem_ready), 128'd0);
      chk("tie_d_rdata", dcache_mem_rdata, LINE_T1);
      cyc();
      chk("tie_idle_gap", 128'(mem_read), 128'd0);
      cyc();
      chk("tie_second_is_i", 128'(mem_addr), 128'h0000100);
      mem_ready = 1'b1;
      mem_rdata = LINE_T2;
      cyc();
      mem_ready = 1'b0;
      chk("tie_i_ready", 128'(icache_mem_ready), 128'd1);
      chk("tie_i_d_quiet", 128'(dcache_mem_ready), 128'd0);
      chk("tie_i_rdata", icache_mem_rdata, LINE_T2);
      chk("tie_d_rdata_hold", dcache_mem_rdata, LINE_T1);
      last_i = LINE_T2;
      last_d = LINE_T1;

      // ---- 4. both sides hold requests: D,I,D,I,D,I
      icache_mem_read = 1'b1;
      icache_mem_addr = 28'h0001000;
      dcache_mem_read = 1'b1;
      dcache_mem_addr = 28'h0002000;
      cyc();
      for (int k = 0; k < 6; k++) begin
         exp_d = (k % 2 == 0);
         dk    = {4{32'hA5A50000 + 32'(k)}};
         wait_grant("alt_grant");
         chk("alt_side", 128'(mem_addr), exp_d ? 128'h0002000 : 128'h0001000);
         repeat (k % 3) cyc();
         mem_ready = 1'b1;
         mem_rdata = dk;
         cyc();
         mem_ready = 1'b0;
         chk("alt_i_ready", 128'(icache_mem_ready), 128'(!exp_d));
         chk("alt_d_ready", 128'(dcache_mem_ready), 128'(exp_d));
         if (exp_d) last_d = dk;
         else       last_i = dk;
         chk("alt_i_rdata", icache_mem_rdata, last_i);
         chk("alt_d_rdata", dcache_mem_rdata, last_d);
         cyc();
         chk("alt_idle", 128'(mem_read | icache_mem_ready | dcache_mem_ready), 128'd0);
      end
      icache_mem_read = 1'b0;
      dcache_mem_read = 1'b0;
      cyc();
      chk("alt_drained", 128'(mem_read | mem_write), 128'd0);

      // ---- 5. write-back latches addr/wdata/op at the grant edge
      dcache_mem_write = 1'b1;
      dcache_mem_addr  = 28'h0ABCDEF;
      dcache_mem_wdata = WDATA_A;
      cyc();
      chk("wb_mem_write", 128'(mem_write), 128'd1);
      chk("wb_mem_read",  128'(mem_read), 128'd0);
      chk("wb_mem_addr",  128'(mem_addr), 128'h0ABCDEF);
      chk("wb_mem_wdata", mem_wdata, WDATA_A);
      dcache_mem_write = 1'b0;
      dcache_mem_addr  = 28'h5555555;
      dcache_mem_wdata = WDATA_B;
      cyc();
      chk("wb_latched_write", 128'(mem_write), 128'd1);
      chk("wb_latched_addr",  128'(mem_addr), 128'h0ABCDEF);
      chk("wb_latched_wdata", mem_wdata, WDATA_A);
      mem_ready = 1'b1;
      mem_rdata = JUNK;
      cyc();
      mem_ready = 1'b0;
      chk("wb_d_ready", 128'(dcache_mem_ready), 128'd1);
      chk("wb_rdata_hold", dcache_mem_rdata, last_d);
      chk("wb_write_drop", 128'(mem_write), 128'd0);
      cyc();

      // ---- 6. spurious mem_ready in IDLE, then read+write together
      mem_ready = 1'b1;
      mem_rdata = JUNK;
      repeat (2) begin
         cyc();
         chk("spur_no_strobe", 128'(mem_read | mem_write), 128'd0);
         chk("spur_no_ready",  128'(icache_mem_ready | dcache_mem_ready), 128'd0);
         chk("spur_i_rdata",   icache_mem_rdata, last_i);
      end
      mem_ready        = 1'b0;
      dcache_mem_read  = 1'b1;
      dcache_mem_write = 1'b1;
      dcache_mem_addr  = 28'h0000123;
      dcache_mem_wdata = WDATA_B;
      cyc();
      chk("rw_is_write", 128'(mem_write), 128'd1);
      chk("rw_no_read",  128'(mem_read), 128'd0);
      chk("rw_wdata",    mem_wdata, WDATA_B);
      mem_ready = 1'b1;
      cyc();
      mem_ready        = 1'b0;
      dcache_mem_read  = 1'b0;
      dcache_mem_write = 1'b0;
      chk("rw_d_ready", 128'(dcache_mem_ready), 128'd1);
      chk("rw_rdata_hold", dcache_mem_rdata, last_d);
      cyc();
      chk("rw_done", 128'(dcache_mem_ready | mem_write), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
